// File: rtl/ib_frame_rx_if.sv
// ib_frame_rx_if: word handshake between the inbound
// frame receiver and its core-side consumer.
interface ib_frame_rx_if;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );
endinterface

// File: rtl/ib_frame_rx.sv
// ib_frame_rx: inbound byte-bus receiver; parity check,
// framed 32-bit word assembly, checksum, FWFT word FIFO.
module ib_frame_rx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  SOF_BYTE   = 8'h7E
) (
  input  logic        ext_clk,
  input  logic        ext_rst_n,
  input  logic [7:0]  ib_data,
  input  logic        ib_pty,
  ib_frame_rx_if.master word_if,
  output logic        err_parity,
  output logic        err_checksum,
  output logic        err_overflow,
  input  logic        err_clr,
  output logic [15:0] frame_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  state_t      state, state_d;
  logic [8:0]  s1, s2;
  logic [1:0]  idx;
  logic [7:0]  csum;
  logic [31:0] word;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;

  logic [7:0] byte_v;
  logic       pgood;
  logic       par_ev, sum_ev, good;
  logic       full, pop, push, ovf_ev;

  assign byte_v = s2[7:0];
  assign pgood  = ^s2;

  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {ib_pty, ib_data};
      s2 <= s1;
    end
  end

  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    par_ev  = 1'b0;
    sum_ev  = 1'b0;
    good    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pgood && byte_v == SOF_BYTE)
          state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (!pgood) begin
          par_ev  = 1'b1;
          state_d = IDLE;
        end else if (idx == 2'd3) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!pgood)              par_ev = 1'b1;
        else if (byte_v != csum) sum_ev = 1'b1;
        else                     good   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      idx  <= '0;
      csum <= '0;
      word <= '0;
    end else if (state == PAYLOAD) begin
      if (pgood) begin
        word[{idx, 3'b000} +: 8] <= byte_v;
        csum <= csum ^ byte_v;
        idx  <= idx + 2'd1;
      end
    end else begin
      idx  <= '0;
      csum <= '0;
    end
  end

  // A full FIFO still takes a push when the head leaves this cycle
  assign full   = (cnt == DEPTH_C);
  assign pop    = word_if.word_valid && word_if.word_ready;
  assign push   = good && (!full || pop);
  assign ovf_ev = good && full && !pop;

  always_ff @(posedge ext_clk) begin
    if (push) mem[wptr] <= word;
  end

  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      frame_count <= '0;
    end else begin
      if (push) begin
        wptr        <= wptr + AW'(1);
        frame_count <= frame_count + 16'd1;
      end
      if (pop) rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign word_if.word_valid = (cnt != '0);
  assign word_if.word_data  =
    word_if.word_valid ? mem[rptr] : '0;

  // A new error in the clearing cycle wins over err_clr
  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      err_parity   <= 1'b0;
      err_checksum <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_parity   <= (err_parity   & ~err_clr) | par_ev;
      err_checksum <= (err_checksum & ~err_clr) | sum_ev;
      err_overflow <= (err_overflow & ~err_clr) | ovf_ev;
    end
  end

endmodule

// File: tb/tb_ib_frame_rx.sv
// tb_ib_frame_rx: directed vectors for ib_frame_rx,
// inputs driven and outputs sampled on the falling edge.
module tb_ib_frame_rx;

  logic        ext_clk = 1'b0;
  logic        ext_rst_n;
  logic [7:0]  ib_data;
  logic        ib_pty;
  logic        err_parity, err_checksum, err_overflow;
  logic        err_clr;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  ib_frame_rx_if wif ();

  ib_frame_rx #(
    .FIFO_DEPTH (4),
    .SOF_BYTE   (8'h7E)
  ) dut (
    .ext_clk      (ext_clk),
    .ext_rst_n    (ext_rst_n),
    .ib_data      (ib_data),
    .ib_pty       (ib_pty),
    .word_if      (wif.master),
    .err_parity   (err_parity),
    .err_checksum (err_checksum),
    .err_overflow (err_overflow),
    .err_clr      (err_clr),
    .frame_count  (frame_count)
  );

  always #5 ext_clk = ~ext_clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic podd(logic [7:0] d);
    return ~^d;
  endfunction

  task automatic send(logic [7:0] d, logic p);
    @(negedge ext_clk);
    ib_data = d;
    ib_pty  = p;
  endtask

  task automatic idle(int n);
    repeat (n) send(8'h00, 1'b0);
  endtask

  task automatic send_frame(logic [31:0] w);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    send(8'h7E, 1'b1);
    for (int i = 0; i < 4; i++) begin
      b  = w[8*i +: 8];
      cs = cs ^ b;
      send(b, podd(b));
    end
    send(cs, podd(cs));
  endtask

  task automatic pop_chk(string tag, logic [31:0] exp);
    @(negedge ext_clk);
    chk({tag, "_v"}, 32'(wif.word_valid), 32'd1);
    chk({tag, "_d"}, wif.word_data, exp);
    wif.word_ready = 1'b1;
    @(negedge ext_clk);
    wif.word_ready = 1'b0;
  endtask

  task automatic errs_chk(string tag, logic [2:0] exp);
    chk(tag, 32'({err_parity, err_checksum, err_overflow}),
        32'(exp));
  endtask

  logic [31:0] ow [6];
  logic [15:0] fc0;

  initial begin
    ext_rst_n      = 1'b0;
    ib_data        = 8'h00;
    ib_pty         = 1'b0;
    err_clr        = 1'b0;
    wif.word_ready = 1'b0;
    ow = '{32'h14131211, 32'h24232221, 32'h34333231,
           32'h44434241, 32'h54535251, 32'h64636261};

    repeat (3) @(negedge ext_clk);
    ext_rst_n = 1'b1;
    @(negedge ext_clk);
    chk("rst_valid", 32'(wif.word_valid), 32'd0);
    chk("rst_data", wif.word_data, 32'd0);
    errs_chk("rst_err", 3'b000);
    chk("rst_fc", 32'(frame_count), 32'd0);

    // good frame and latency
    send_frame(32'h44332211);
    idle(2);
    chk("lat_e1_valid", 32'(wif.word_valid), 32'd0);
    idle(1);
    chk("lat_e2_valid", 32'(wif.word_valid), 32'd1);
    chk("good_data", wif.word_data, 32'h44332211);
    chk("good_fc", 32'(frame_count), 32'd1);
    errs_chk("good_err", 3'b000);
    pop_chk("good_pop", 32'h44332211);
    chk("pop_valid", 32'(wif.word_valid), 32'd0);
    chk("pop_data", wif.word_data, 32'd0);

    // parity error in third payload byte
    send(8'h7E, 1'b1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    send(8'h44, 1'b1);
    idle(3);
    errs_chk("par_err", 3'b100);
    chk("par_valid", 32'(wif.word_valid), 32'd0);
    chk("par_fc", 32'(frame_count), 32'd1);
    send_frame(32'h04030201);
    idle(3);
    chk("par_next_fc", 32'(frame_count), 32'd2);
    pop_chk("par_next", 32'h04030201);
    err_clr = 1'b1;
    @(negedge ext_clk);
    err_clr = 1'b0;
    errs_chk("par_clr", 3'b000);

    // checksum error
    send(8'h7E, 1'b1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    send(8'h45, 1'b0);
    idle(3);
    errs_chk("sum_err", 3'b010);
    chk("sum_valid", 32'(wif.word_valid), 32'd0);
    chk("sum_fc", 32'(frame_count), 32'd2);
    err_clr = 1'b1;
    @(negedge ext_clk);
    err_clr = 1'b0;
    errs_chk("sum_clr", 3'b000);

    // overflow: five back-to-back frames into depth 4
    fc0 = frame_count;
    for (int i = 0; i < 5; i++) send_frame(ow[i]);
    idle(3);
    errs_chk("ovf_err", 3'b001);
    chk("ovf_fc", 32'(frame_count), 32'(fc0 + 16'd4));
    chk("ovf_head", wif.word_data, ow[0]);
    err_clr = 1'b1;
    @(negedge ext_clk);
    err_clr = 1'b0;
    // sixth frame pushes in the same cycle as a pop
    send_frame(ow[5]);
    idle(2);
    chk("ovf6_head", wif.word_data, ow[0]);
    wif.word_ready = 1'b1;
    idle(1);
    wif.word_ready = 1'b0;
    errs_chk("ovf6_err", 3'b000);
    chk("ovf6_fc", 32'(frame_count), 32'(fc0 + 16'd5));
    pop_chk("ovf_w1", ow[1]);
    pop_chk("ovf_w2", ow[2]);
    pop_chk("ovf_w3", ow[3]);
    pop_chk("ovf_w5", ow[5]);
    chk("ovf_empty", 32'(wif.word_valid), 32'd0);

    // framing: stray bytes, bad-parity SOF, SOF inside payload
    fc0 = frame_count;
    send(8'h00, 1'b1);
    send(8'h7E, 1'b0);
    send_frame(32'h557EAA7E);
    idle(3);
    chk("frm_fc", 32'(frame_count), 32'(fc0 + 16'd1));
    errs_chk("frm_err", 3'b000);
    pop_chk("frm_word", 32'h557EAA7E);
    chk("frm_empty", 32'(wif.word_valid), 32'd0);

    // reset mid-frame with one word held
    send_frame(32'h44332211);
    idle(3);
    chk("mid_pre_valid", 32'(wif.word_valid), 32'd1);
    send(8'h7E, 1'b1);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    @(negedge ext_clk);
    ext_rst_n = 1'b0;
    ib_data   = 8'h33;
    ib_pty    = 1'b1;
    @(negedge ext_clk);
    chk("mid_rst_valid", 32'(wif.word_valid), 32'd0);
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    ext_rst_n = 1'b1;
    ib_data   = 8'h44;
    ib_pty    = 1'b1;
    send(8'h44, 1'b1);
    idle(4);
    chk("mid_tail_valid", 32'(wif.word_valid), 32'd0);
    chk("mid_tail_fc", 32'(frame_count), 32'd0);
    errs_chk("mid_tail_err", 3'b000);
    send_frame(32'hA1B2C3D4);
    idle(3);
    chk("mid_next_fc", 32'(frame_count), 32'd1);
    chk("mid_next_data", wif.word_data, 32'hA1B2C3D4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ib_frame_rx.md
Name: ib_frame_rx

Overview:
Inbound receiver for the off-chip byte bus (io pins 28-36: 8 data bits plus 1 parity bit). It registers the pad inputs into the ext_clk domain and checks parity on every byte. It assembles framed 32-bit words, verifies a per-frame checksum, and buffers good words in a small FIFO for the core-side consumer over a valid/ready interface. It sits directly downstream of the top-level pad wrapper's ib_data/ib_pty signals.

Parameters:
FIFO_DEPTH, 4, number of 32-bit word entries; must be a power of 2, at least 2.
SOF_BYTE, 8'h7E, start-of-frame marker byte.

Ports:
ext_clk  input  1  core clock; all logic on its rising edge.
ext_rst_n  input  1  reset, synchronous, active-low.
ib_data  input  8  inbound bus data byte from the pads.
ib_pty  input  1  inbound odd-parity bit from the pads.
word_valid  output  1  FIFO head holds a valid word.
word_ready  input  1  consumer accepts the head word this cycle.
word_data  output  32  FIFO head word; 0 when empty.
err_parity  output  1  sticky flag: parity error seen inside a frame.
err_checksum  output  1  sticky flag: frame checksum mismatch.
err_overflow  output  1  sticky flag: good frame dropped because the FIFO was full.
err_clr  input  1  clears all sticky error flags.
frame_count  output  16  count of good frames pushed into the FIFO; wraps.

Behaviour:
- Reset (ext_rst_n=0 at a rising edge):
  - Sync registers cleared to 0; FSM to IDLE; FIFO emptied.
  - word_valid=0, word_data=0, all err_*=0, frame_count=0.
  - A reset mid-frame discards the partial frame; no error is flagged.
- Input path:
  - Two register stages (s1, s2) on {ib_pty, ib_data}. The FSM evaluates s2 only.
  - One byte is consumed per ext_clk cycle. There is no idle qualifier; framing alone delimits data.
- Parity: a byte is good when the XOR of all 9 bits equals 1 (odd parity).
- FSM states:
  - IDLE: if s2 equals SOF_BYTE with good parity, go to PAYLOAD with idx=0 and running XOR csum=0. Every other byte, including a SOF with bad parity, is ignored silently.
  - PAYLOAD: bad parity sets err_parity, drops the frame, goes to IDLE. Otherwise store the byte into word[8*idx +: 8] (little-endian, first byte = bits 7:0), csum ^= byte, idx++. After idx=3 is stored, go to CHECK. A SOF value here is plain data; there is no resync.
  - CHECK: bad parity sets err_parity and drops the frame. Byte != csum sets err_checksum and drops the frame. Otherwise the frame is good: push the word if the FIFO has room, else set err_overflow and drop. Always return to IDLE. The byte following a CHECK byte is evaluated in IDLE.
- Latency: the checksum byte is present on the pins before edge E0. It reaches s2 at E1. The FIFO write and frame_count increment occur at E2, and word_valid is high from E2 onward, if the FIFO was empty. Minimum frame spacing is 6 cycles; back-to-back frames are supported.
- FIFO:
  - Pop occurs when word_valid && word_ready. Output is the head combinationally from storage (first-word fall-through).
  - Push while full with a simultaneous pop is accepted; there is no overflow.
  - Push while empty becomes visible at the next edge; there is no same-cycle bypass.
  - word_ready while empty has no effect.
- frame_count: +1 on each accepted push; 16'hFFFF wraps to 16'h0000. Dropped frames are not counted.
- err_clr: clears the flags at the next edge. If an error event and err_clr occur in the same cycle, the error flag ends set.

Test Plan:
- Good frame: pins 7E/1, 11/1, 22/1, 33/1, 44/1, 44/1 on consecutive cycles -> word_valid rises 3 edges after the last byte; word_data=32'h44332211; frame_count=1; all err=0; pop with word_ready=1 -> word_valid=0, word_data=0.
- Parity error: the same frame with the third payload byte sent as 33/0 -> err_parity=1, no push, frame_count unchanged. A following good frame is accepted normally.
- Checksum error: the same frame with checksum 45/0 (parity good) -> err_checksum=1, no push. Then err_clr=1 for one cycle -> err_checksum=0.
- Overflow: word_ready=0, send 5 good frames with FIFO_DEPTH=4 -> 4 words held in order, err_overflow=1, frame_count=4. A 6th frame whose push coincides with a pop -> accepted, no new overflow.
- Framing: bytes 00/1, 7E/0, then a good frame whose payload contains 7E -> only one word pushed, 7E appears in the payload position, no errors.
- Reset mid-frame: drive ext_rst_n=0 after 2 payload bytes with one word in the FIFO -> FIFO empty, frame_count=0, FSM in IDLE; the remaining bytes of the aborted frame are ignored until the next SOF.
